// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared types, defaults and helpers for the tpu_gemm_array slice
package tpu_pkg;

    localparam int TPU_ARRAY_DIM = 4;
    localparam int TPU_DATA_W    = 8;
    localparam int TPU_ACC_W     = 32;
    localparam int TPU_OUT_W     = 8;
    localparam int TPU_ADDR_W    = 8;
    localparam int TPU_DIM_W     = 5;

    // Saturation works on a 64-bit extended accumulator and returns up to 32 output bits.
    localparam int TPU_SAT_W     = 64;
    localparam int TPU_OUT_MAX   = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COMPUTE,
        S_WRITE,
        S_DONE
    } tpu_state_e;

    // Lane 0 is the most significant slice of a buffer word.
    function automatic int tpu_lane_msb(input int lanes, input int lane, input int w);
        return (lanes - lane) * w - 1;
    endfunction

    // acc must already be sign-extended (signed mode) or zero-extended (unsigned mode).
    function automatic logic [TPU_OUT_MAX-1:0] tpu_sat(
        input logic [TPU_SAT_W-1:0] acc,
        input int                   out_w,
        input logic                 is_signed,
        input logic                 sat_en
    );
        logic signed [TPU_SAT_W-1:0] v_s;
        logic signed [TPU_SAT_W-1:0] v_hi;
        logic signed [TPU_SAT_W-1:0] v_lo;
        logic        [TPU_SAT_W-1:0] v_umax;
        logic        [TPU_OUT_MAX-1:0] v_res;
        v_s    = $signed(acc);
        v_hi   = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        v_lo   = -(64'sd1 <<< (out_w - 1));
        v_umax = (64'd1 << out_w) - 64'd1;
        v_res  = TPU_OUT_MAX'(acc);
        if (sat_en) begin
            if (is_signed) begin
                if (v_s > v_hi)      v_res = TPU_OUT_MAX'(v_hi);
                else if (v_s < v_lo) v_res = TPU_OUT_MAX'(v_lo);
            end else if (acc > v_umax) begin
                v_res = TPU_OUT_MAX'(v_umax);
            end
        end
        return v_res;
    endfunction

endpackage

// File: rtl/tpu_mac_pe.sv
// rtl/tpu_mac_pe.sv - systolic MAC processing element with registered a/b pass-through
// Ports: clk, rst (sync active-high), i_clr (zero acc and pass regs), i_en (advance),
//        i_signed (two's-complement operands), i_a/i_b (operands in), o_a/o_b (to right/down
//        neighbour), o_acc (accumulator, wraps modulo 2^ACC_W).
module tpu_mac_pe
    import tpu_pkg::*;
#(
    parameter int DATA_W = TPU_DATA_W,
    parameter int ACC_W  = TPU_ACC_W
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic              i_signed,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_b,
    output logic [ACC_W-1:0]  o_acc
);

    localparam int PW = 2 * DATA_W + 2;

    logic signed [PW-1:0] w_a_x;
    logic signed [PW-1:0] w_b_x;
    logic signed [PW-1:0] w_prod;
    logic [ACC_W-1:0]     w_prod_ext;

    // One extra bit carries the operand sign in signed mode and a zero in unsigned mode,
    // so a single signed multiplier covers both; the unsigned product is never negative.
    assign w_a_x      = PW'($signed({i_signed & i_a[DATA_W-1], i_a}));
    assign w_b_x      = PW'($signed({i_signed & i_b[DATA_W-1], i_b}));
    assign w_prod     = w_a_x * w_b_x;
    assign w_prod_ext = ACC_W'(w_prod);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            o_a   <= '0;
            o_b   <= '0;
            o_acc <= '0;
        end else if (i_en) begin
            o_a   <= i_a;
            o_b   <= i_b;
            o_acc <= o_acc + w_prod_ext;
        end
    end

endmodule

// File: rtl/tpu_gemm_array.sv
// rtl/tpu_gemm_array.sv - output-stationary systolic GEMM engine, C = A x B, tiled over ARRAY_DIM^2 PEs
// Ports: clk/rst (sync active-high); start, m, n, k, signed_mode, sat_en (job setup, latched on start);
//        data_in_a/b (buffer words, valid 1 cycle after index_a/b); data_in_o (unused);
//        wr_en_a/b (tied 0); wr_en_o, index_o, data_out_o (C row writes); index_a/b (reads);
//        busy (not IDLE); done (1-cycle completion pulse).
module tpu_gemm_array
    import tpu_pkg::*;
#(
    parameter int ARRAY_DIM = TPU_ARRAY_DIM,
    parameter int DATA_W    = TPU_DATA_W,
    parameter int ACC_W     = TPU_ACC_W,
    parameter int OUT_W     = TPU_OUT_W,
    parameter int ADDR_W    = TPU_ADDR_W,
    parameter int DIM_W     = TPU_DIM_W
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [DIM_W-1:0]            m,
    input  logic [DIM_W-1:0]            n,
    input  logic [DIM_W-1:0]            k,
    input  logic                        signed_mode,
    input  logic                        sat_en,
    input  logic [ARRAY_DIM*DATA_W-1:0] data_in_a,
    input  logic [ARRAY_DIM*DATA_W-1:0] data_in_b,
    input  logic [ARRAY_DIM*OUT_W-1:0]  data_in_o,
    output logic                        wr_en_a,
    output logic                        wr_en_b,
    output logic                        wr_en_o,
    output logic [ADDR_W-1:0]           index_a,
    output logic [ADDR_W-1:0]           index_b,
    output logic [ADDR_W-1:0]           index_o,
    output logic [ARRAY_DIM*OUT_W-1:0]  data_out_o,
    output logic                        busy,
    output logic                        done
);

    localparam int XW = ADDR_W + DIM_W + 4;
    localparam int RW = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
    localparam logic [XW-1:0] AD_X = XW'(ARRAY_DIM);

    tpu_state_e r_state, w_next;

    logic [DIM_W-1:0] r_m, r_n, r_k;
    logic             r_signed, r_sat;
    logic [XW-1:0]    r_cnt, r_tm, r_tn;
    logic [RW-1:0]    r_row;
    logic             r_rd_vld;

    logic [XW-1:0] w_m, w_n, w_k, w_rem_m, w_rem_n, w_rows_valid, w_cols_valid;
    logic          w_last_tm, w_last_tn, w_cnt_last, w_row_last, w_issue, w_clr, w_en;
    logic          w_unused_in;

    assign w_m          = XW'(r_m);
    assign w_n          = XW'(r_n);
    assign w_k          = XW'(r_k);
    assign w_rem_m      = w_m - r_tm * AD_X;
    assign w_rem_n      = w_n - r_tn * AD_X;
    assign w_rows_valid = (w_rem_m > AD_X) ? AD_X : w_rem_m;
    assign w_cols_valid = (w_rem_n > AD_X) ? AD_X : w_rem_n;
    assign w_last_tm    = ((r_tm + XW'(1)) * AD_X) >= w_m;
    assign w_last_tn    = ((r_tn + XW'(1)) * AD_X) >= w_n;
    // The last operand pair reaches PE(D-1,D-1) at cnt = k + 2D - 2; one spare cycle lets it settle.
    assign w_cnt_last   = r_cnt == (w_k + XW'(2 * ARRAY_DIM - 1));
    assign w_row_last   = XW'(r_row) == (w_rows_valid - XW'(1));
    assign w_issue      = (r_state == S_COMPUTE) && (r_cnt < w_k);
    assign w_clr        = r_state == S_CLEAR;
    assign w_en         = r_state == S_COMPUTE;
    assign w_unused_in  = ^data_in_o;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = (m == '0 || n == '0 || k == '0) ? S_DONE : S_CLEAR;
            S_CLEAR:   w_next = S_COMPUTE;
            S_COMPUTE: if (w_cnt_last) w_next = S_WRITE;
            S_WRITE:   if (w_row_last) w_next = (w_last_tm && w_last_tn) ? S_DONE : S_CLEAR;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m      <= '0;
            r_n      <= '0;
            r_k      <= '0;
            r_signed <= 1'b0;
            r_sat    <= 1'b0;
            r_cnt    <= '0;
            r_tm     <= '0;
            r_tn     <= '0;
            r_row    <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= w_issue;
            case (r_state)
                S_IDLE: if (start) begin
                    r_m      <= m;
                    r_n      <= n;
                    r_k      <= k;
                    r_signed <= signed_mode;
                    r_sat    <= sat_en;
                    r_tm     <= '0;
                    r_tn     <= '0;
                end
                S_CLEAR: begin
                    r_cnt <= '0;
                    r_row <= '0;
                end
                S_COMPUTE: r_cnt <= r_cnt + XW'(1);
                S_WRITE: begin
                    r_row <= r_row + RW'(1);
                    if (w_row_last) begin
                        // tm is the inner tile loop, tn the outer
                        if (w_last_tm) begin
                            r_tm <= '0;
                            r_tn <= r_tn + XW'(1);
                        end else begin
                            r_tm <= r_tm + XW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    logic [DATA_W-1:0] w_a_pipe [ARRAY_DIM][ARRAY_DIM+1];
    logic [DATA_W-1:0] w_b_pipe [ARRAY_DIM+1][ARRAY_DIM];
    logic [ACC_W-1:0]  w_acc    [ARRAY_DIM][ARRAY_DIM];

    // Lane i feeds A row i and B column i. Out-of-tile lanes and cycles with no read in flight
    // inject zeros, so the array only ever accumulates real operand pairs.
    for (genvar i = 0; i < ARRAY_DIM; i++) begin : g_lane
        logic [DATA_W-1:0] w_a_lane, w_b_lane;
        assign w_a_lane = (r_rd_vld && (XW'(i) < w_rows_valid)) ?
                          data_in_a[tpu_lane_msb(ARRAY_DIM, i, DATA_W) -: DATA_W] : '0;
        assign w_b_lane = (r_rd_vld && (XW'(i) < w_cols_valid)) ?
                          data_in_b[tpu_lane_msb(ARRAY_DIM, i, DATA_W) -: DATA_W] : '0;
        if (i == 0) begin : g_direct
            assign w_a_pipe[i][0] = w_a_lane;
            assign w_b_pipe[0][i] = w_b_lane;
        end else begin : g_skew
            // i-stage delay line so row/column i enters the grid i cycles late
            logic [DATA_W-1:0] r_a_sk [i];
            logic [DATA_W-1:0] r_b_sk [i];
            always_ff @(posedge clk) begin
                if (rst || w_clr) begin
                    for (int s = 0; s < i; s++) begin
                        r_a_sk[s] <= '0;
                        r_b_sk[s] <= '0;
                    end
                end else begin
                    r_a_sk[0] <= w_a_lane;
                    r_b_sk[0] <= w_b_lane;
                    for (int s = 1; s < i; s++) begin
                        r_a_sk[s] <= r_a_sk[s-1];
                        r_b_sk[s] <= r_b_sk[s-1];
                    end
                end
            end
            assign w_a_pipe[i][0] = r_a_sk[i-1];
            assign w_b_pipe[0][i] = r_b_sk[i-1];
        end
    end

    for (genvar r = 0; r < ARRAY_DIM; r++) begin : g_r
        for (genvar c = 0; c < ARRAY_DIM; c++) begin : g_c
            tpu_mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
                .clk      (clk),
                .rst      (rst),
                .i_clr    (w_clr),
                .i_en     (w_en),
                .i_signed (r_signed),
                .i_a      (w_a_pipe[r][c]),
                .i_b      (w_b_pipe[r][c]),
                .o_a      (w_a_pipe[r][c+1]),
                .o_b      (w_b_pipe[r+1][c]),
                .o_acc    (w_acc[r][c])
            );
        end
    end

    always_comb begin
        logic [TPU_SAT_W-1:0] v_ext;
        v_ext      = '0;
        data_out_o = '0;
        if (r_state == S_WRITE) begin
            for (int c = 0; c < ARRAY_DIM; c++) begin
                v_ext = r_signed ? {{(TPU_SAT_W-ACC_W){w_acc[r_row][c][ACC_W-1]}}, w_acc[r_row][c]}
                                 : {{(TPU_SAT_W-ACC_W){1'b0}}, w_acc[r_row][c]};
                if (XW'(c) < w_cols_valid)
                    data_out_o[tpu_lane_msb(ARRAY_DIM, c, OUT_W) -: OUT_W] =
                        OUT_W'(tpu_sat(v_ext, OUT_W, r_signed, r_sat));
            end
        end
    end

    assign wr_en_a = 1'b0;
    assign wr_en_b = 1'b0;
    assign wr_en_o = r_state == S_WRITE;
    assign busy    = r_state != S_IDLE;
    assign done    = r_state == S_DONE;
    assign index_a = w_issue ? ADDR_W'(r_tm * w_k + r_cnt) : '0;
    assign index_b = w_issue ? ADDR_W'(r_tn * w_k + r_cnt) : '0;
    assign index_o = wr_en_o ? ADDR_W'(r_tn * w_m + r_tm * AD_X + XW'(r_row)) : '0;

endmodule

// File: doc/tpu_gemm_array.md
Name: tpu_gemm_array

Overview:
- Parametrised output-stationary systolic GEMM engine; successor to the fixed 4x4, 8-bit TPU core.
- Computes C = A x B for A (m x k) and B (k x n), tiling m and n over an ARRAY_DIM x ARRAY_DIM PE grid and streaming k through the grid.
- Adds signed/unsigned operand mode, saturating output, edge-tile masking and a busy/done handshake.
- Reads operands from the A/B global buffers and writes C to the output buffer.

Parameters:
- ARRAY_DIM, 4: PE rows = PE columns = lanes per buffer word.
- DATA_W, 8: operand element width.
- ACC_W, 32: accumulator width.
- OUT_W, 8: output element width.
- ADDR_W, 8: buffer index width.
- DIM_W, 5: width of m/n/k.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begin job; sampled only in IDLE.
- m, n, k  in  DIM_W each  matrix dimensions; latched on start.
- signed_mode  in  1  1 = two's-complement operands; latched on start.
- sat_en  in  1  1 = saturate outputs; latched on start.
- data_in_a  in  ARRAY_DIM*DATA_W  A word, valid 1 cycle after index_a.
- data_in_b  in  ARRAY_DIM*DATA_W  B word, valid 1 cycle after index_b.
- data_in_o  in  ARRAY_DIM*OUT_W  unused; kept for buffer compatibility.
- wr_en_a, wr_en_b  out  1 each  constant 0.
- wr_en_o  out  1  output-buffer write strobe.
- index_a, index_b, index_o  out  ADDR_W each  buffer indices.
- data_out_o  out  ARRAY_DIM*OUT_W  C row word.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: one clock + synchronous active-high reset (clk, rst). Reset forces state IDLE, all counters/accumulators 0, and every output 0. Reset mid-job aborts it; no further writes.
- Memory layout; lane 0 is the most significant slice in every word.
  - A word at tm*k+kk: A[tm*ARRAY_DIM+r][kk], lane r.
  - B word at tn*k+kk: B[kk][tn*ARRAY_DIM+c], lane c.
  - C word at tn*m+tm*ARRAY_DIM+r: C[row][tn*ARRAY_DIM+c], lane c.
  - Indices truncate to ADDR_W.
- Tiling: tile count T = ceil(dim/ARRAY_DIM). tm is the inner loop, tn the outer loop.
- FSM states: IDLE, CLEAR, COMPUTE, WRITE, DONE.
  - IDLE: start=1 latches inputs and moves to CLEAR. If m, n or k is 0, go directly to DONE with no reads or writes.
  - CLEAR (1 cycle): zero all accumulators and skew registers.
  - COMPUTE: counter cnt runs 0..k+2*ARRAY_DIM-1 (k+2*ARRAY_DIM cycles).
    - At cnt<k, issue index_a/index_b for kk=cnt.
    - Returned lanes r>=rows_valid (A) and c>=cols_valid (B) are forced to 0.
    - Row r is skewed by r cycles, column c by c cycles. The A operand moves right and the B operand moves down, one PE per cycle.
    - PE(r,c) consumes element kk at cycle T0+1+kk+r+c.
  - WRITE: rows_valid cycles. Each cycle wr_en_o=1, index_o=tn*m+tm*ARRAY_DIM+r, data_out_o = row r of the accumulators. Lanes c>=cols_valid are written as 0.
    - After the last row: go to CLEAR for the next tile, or to DONE after the final tile.
  - DONE (1 cycle): done=1, then IDLE.
- Per-tile latency: 1 + k + 2*ARRAY_DIM + rows_valid cycles.
- Arithmetic:
  - Product is 2*DATA_W bits, sign- or zero-extended per signed_mode, then added to the accumulator. The accumulator wraps modulo 2^ACC_W.
  - Output with sat_en=0: low OUT_W bits.
  - Output with sat_en=1, signed: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Output with sat_en=1, unsigned: clamp to 2^OUT_W-1.
- Handshake:
  - start while busy is ignored.
  - m/n/k/mode changes after start have no effect.
  - start asserted in the same cycle as done is ignored; a new job needs start in IDLE.

Decomposition:
- Shared package tpu_pkg:
  - State encoding.
  - Lane slice helper: lane i = bits [(ARRAY_DIM-i)*W-1 -: W].
  - Saturation function.
  - Default parameter constants.
- One natural sub-module, tpu_mac_pe:
  - Registered a/b pass-through.
  - Accumulator with clear and enable.
  - Signed-mode multiply.
  - Instantiated ARRAY_DIM^2 times via generate.

Test Plan:
- Identity: defaults, m=n=k=4, A=I, B rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}. Required: 4 writes to index_o 0..3 equal to the B rows; done 1 cycle after the last write; total 1+4+8+4 cycles from CLEAR to the last write.
- Edge tiles: m=6, n=5, k=3, all A=1, B=2. Required: every C element = 6. Writes per (tn,tm):
  - (0,0): index 0..3.
  - (0,1): index 4..5.
  - (1,0): index 6..9.
  - (1,1): index 10..11.
  - Lanes 1..3 are 0 in tn=1 words.
  - 12 writes total.
- Saturation: m=n=k=1, signed_mode=1, A=-128, B=-128 (product 16384).
  - sat_en=1: output 0x7F.
  - sat_en=0: output 0x00.
  - signed_mode=1, sat_en=1, A=-128, B=127: output 0x80.
- Zero dimension: start with k=0. Required: no reads, no wr_en_o, done 1 cycle later, busy high exactly 1 cycle.
- Reset mid-run: assert rst at COMPUTE cnt=3 of a 4x4x4 job. Required: next cycle all outputs 0, state IDLE; a restarted identical job gives correct results.
- start pulsed during WRITE: ignored; exactly one done; outputs unchanged.
